// File: rtl/burst_ram_model.sv
// burst_ram_model: byte-addressed burst memory with concurrent write and read channels
module burst_ram_model #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 30,
    parameter int MEM_BYTES  = 8192,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]              wr_len,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    wr_busy,
    output logic                    wr_done,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [7:0]              rd_len,
    output logic                    rd_busy,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    err
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int MW  = $clog2(MEM_BYTES);
    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_BURST = 1'b1;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_DRAIN = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_TOP    = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BPB);

    logic [7:0] mem [MEM_BYTES] = '{default: '0};
    logic [0:0] w_state;
    logic [1:0] r_state;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0] w_cnt, r_cnt;
    logic w_fire, w_in, r_fire, r_in;
    logic [DATA_WIDTH-1:0] r_word;
    logic [RD_LATENCY-1:0] p_valid, p_last;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] p_data;

    assign w_fire   = (w_state == W_BURST) && wr_valid;
    assign w_in     = w_addr < MEM_TOP;
    assign r_fire   = r_state == R_ISSUE;
    assign r_in     = r_addr < MEM_TOP;
    assign wr_busy  = w_state == W_BURST;
    assign rd_busy  = r_state != R_IDLE;
    assign rd_valid = p_valid[RD_LATENCY-1];
    assign rd_last  = p_last[RD_LATENCY-1];
    assign rd_data  = p_data[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_cnt   <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (w_state == W_IDLE) begin
                if (wr_req) begin
                    w_state <= W_BURST;
                    w_addr  <= wr_addr & ALIGN_MASK;
                    w_cnt   <= wr_len;
                end
            end else if (wr_valid) begin
                w_addr <= w_addr + STEP;
                w_cnt  <= w_cnt - 8'd1;
                if (w_cnt == 8'd0) begin
                    w_state <= W_IDLE;
                    wr_done <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset so a reset mid-burst leaves already written beats intact
    always_ff @(posedge clk) begin
        if (w_fire && w_in)
            for (int i = 0; i < BPB; i++)
                if (wr_strb[i]) mem[w_addr[MW-1:0] + MW'(i)] <= wr_data[DATA_WIDTH-1-8*i -: 8];
    end

    always_comb begin
        r_word = '0;
        for (int i = 0; i < BPB; i++)
            r_word[DATA_WIDTH-1-8*i -: 8] = mem[r_addr[MW-1:0] + MW'(i)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else if (r_state == R_IDLE) begin
            if (rd_req) begin
                r_state <= R_ISSUE;
                r_addr  <= rd_addr & ALIGN_MASK;
                r_cnt   <= rd_len;
            end
        end else if (r_fire) begin
            r_addr <= r_addr + STEP;
            r_cnt  <= r_cnt - 8'd1;
            if (r_cnt == 8'd0) r_state <= R_DRAIN;
        end else if (rd_valid && rd_last) begin
            r_state <= R_IDLE;
        end
    end

    // Memory is sampled at issue, so a same-edge write is seen only by later beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= '0;
            p_last  <= '0;
            p_data  <= '0;
        end else begin
            p_valid[0] <= r_fire;
            p_last[0]  <= r_fire && (r_cnt == 8'd0);
            p_data[0]  <= (r_fire && r_in) ? r_word : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_last[i]  <= p_last[i-1];
                p_data[i]  <= p_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if ((w_fire && !w_in) || (r_fire && !r_in)) err <= 1'b1;
    end
endmodule

// File: tb/tb_burst_ram_model.sv
// tb_burst_ram_model: scoreboard bench for latency-1 and latency-4 instances
module tb_burst_ram_model;
    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic        wr_req[2], wr_valid[2], wr_busy[2], wr_done[2];
    logic        rd_req[2], rd_busy[2], rd_valid[2], rd_last[2], err[2];
    logic [29:0] wr_addr[2], rd_addr[2];
    logic [7:0]  wr_len[2], rd_len[2], wr_strb[2];
    logic [63:0] wr_data[2], rd_data[2];
    exp_t q0[$], q1[$];
    int cyc = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    burst_ram_model #(.RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_len(wr_len[0]),
        .wr_valid(wr_valid[0]), .wr_data(wr_data[0]), .wr_strb(wr_strb[0]), .wr_busy(wr_busy[0]),
        .wr_done(wr_done[0]), .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_len(rd_len[0]),
        .rd_busy(rd_busy[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_last(rd_last[0]),
        .err(err[0])
    );

    burst_ram_model #(.RD_LATENCY(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_len(wr_len[1]),
        .wr_valid(wr_valid[1]), .wr_data(wr_data[1]), .wr_strb(wr_strb[1]), .wr_busy(wr_busy[1]),
        .wr_done(wr_done[1]), .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_len(rd_len[1]),
        .rd_busy(rd_busy[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_last(rd_last[1]),
        .err(err[1])
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(int d, logic [63:0] data, logic last, int c);
        exp_t e;
        e.data = data;
        e.last = last;
        e.cyc  = c;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid[0]) begin
            chk("rd0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("rd0_data", rd_data[0], e.data);
                chk("rd0_last", 64'(rd_last[0]), 64'(e.last));
                chk("rd0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else chk("rd0_idle_data", rd_data[0], 64'd0);
        if (rd_valid[1]) begin
            chk("rd1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("rd1_data", rd_data[1], e.data);
                chk("rd1_last", 64'(rd_last[1]), 64'(e.last));
                chk("rd1_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else chk("rd1_idle_data", rd_data[1], 64'd0);
    end

    task automatic wr_burst(int d, logic [29:0] a, logic [7:0] len, logic [63:0] d0, logic [7:0] s);
        @(negedge clk);
        wr_req[d] = 1'b1;
        wr_addr[d] = a;
        wr_len[d] = len;
        @(negedge clk);
        wr_req[d] = 1'b0;
        chk("wr_busy_start", 64'(wr_busy[d]), 64'd1);
        for (int k = 0; k <= int'(len); k++) begin
            wr_valid[d] = 1'b1;
            wr_data[d] = d0 + 64'(k);
            wr_strb[d] = s;
            @(negedge clk);
        end
        wr_valid[d] = 1'b0;
        chk("wr_done_pulse", 64'(wr_done[d]), 64'd1);
        chk("wr_busy_end", 64'(wr_busy[d]), 64'd0);
        @(negedge clk);
        chk("wr_done_clear", 64'(wr_done[d]), 64'd0);
    endtask

    // c0 is the cycle count right after the request edge
    task automatic rd_start(int d, logic [29:0] a, logic [7:0] len, output int c0);
        @(negedge clk);
        rd_req[d] = 1'b1;
        rd_addr[d] = a;
        rd_len[d] = len;
        c0 = cyc + 1;
        @(negedge clk);
        rd_req[d] = 1'b0;
        chk("rd_busy_start", 64'(rd_busy[d]), 64'd1);
    endtask

    task automatic wait_rd_idle(int d, int drop);
        int n = 0;
        while (rd_busy[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rd_busy_drop_cycle", 64'(cyc), 64'(drop));
    endtask

    initial begin
        int c;
        for (int d = 0; d < 2; d++) begin
            wr_req[d] = 1'b0; wr_valid[d] = 1'b0; rd_req[d] = 1'b0;
            wr_addr[d] = '0; rd_addr[d] = '0; wr_len[d] = '0; rd_len[d] = '0;
            wr_strb[d] = '0; wr_data[d] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_wr_busy", 64'(wr_busy[d]), 64'd0);
            chk("rst_wr_done", 64'(wr_done[d]), 64'd0);
            chk("rst_rd_busy", 64'(rd_busy[d]), 64'd0);
            chk("rst_rd_last", 64'(rd_last[d]), 64'd0);
            chk("rst_err", 64'(err[d]), 64'd0);
        end
        rst_n = 1'b1;

        wr_burst(0, 30'h10, 8'd3, 64'h1, 8'hFF);
        rd_start(0, 30'h10, 8'd3, c);
        for (int k = 0; k < 4; k++) expect_beat(0, 64'(k + 1), k == 3, c + 1 + k);
        wait_rd_idle(0, c + 5);

        wr_burst(0, 30'h40, 8'd0, 64'h1122334455667788, 8'hFF);
        wr_burst(0, 30'h40, 8'd0, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd_start(0, 30'h40, 8'd0, c);
        expect_beat(0, 64'hAAAAAAAA55667788, 1'b1, c + 1);
        wait_rd_idle(0, c + 2);

        rd_start(0, 30'h45, 8'd0, c);
        expect_beat(0, 64'hAAAAAAAA55667788, 1'b1, c + 1);
        wait_rd_idle(0, c + 2);
        chk("err_unaligned", 64'(err[0]), 64'd0);

        wr_burst(0, 30'h1FF8, 8'd1, 64'h0123456789ABCDEF, 8'hFF);
        chk("err_set", 64'(err[0]), 64'd1);
        rd_start(0, 30'h1FF8, 8'd1, c);
        expect_beat(0, 64'h0123456789ABCDEF, 1'b0, c + 1);
        expect_beat(0, 64'h0, 1'b1, c + 2);
        wait_rd_idle(0, c + 3);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err[0]), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("err_cleared", 64'(err[0]), 64'd0);

        wr_burst(1, 30'h100, 8'd7, 64'hA0, 8'hFF);
        fork
            begin
                rd_start(1, 30'h100, 8'd7, c);
                for (int k = 0; k < 8; k++) expect_beat(1, 64'hA0 + 64'(k), k == 7, c + 4 + k);
                wait_rd_idle(1, c + 12);
            end
            wr_burst(1, 30'h200, 8'd3, 64'hB0, 8'hFF);
        join
        rd_start(1, 30'h200, 8'd3, c);
        for (int k = 0; k < 4; k++) expect_beat(1, 64'hB0 + 64'(k), k == 3, c + 4 + k);
        wait_rd_idle(1, c + 8);
        chk("err_lat4", 64'(err[1]), 64'd0);

        rd_start(1, 30'h100, 8'd7, c);
        for (int k = 0; k < 8; k++) expect_beat(1, 64'hA0 + 64'(k), k == 7, c + 4 + k);
        while (cyc < c + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd_valid", 64'(rd_valid[1]), 64'd0);
        chk("async_rd_busy", 64'(rd_busy[1]), 64'd0);
        chk("async_rd_last", 64'(rd_last[1]), 64'd0);
        chk("async_rd_data", rd_data[1], 64'd0);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rd_start(1, 30'h100, 8'd1, c);
        expect_beat(1, 64'hA0, 1'b0, c + 4);
        expect_beat(1, 64'hA1, 1'b1, c + 5);
        wait_rd_idle(1, c + 6);
        rd_start(0, 30'h40, 8'd0, c);
        expect_beat(0, 64'hAAAAAAAA55667788, 1'b1, c + 1);
        wait_rd_idle(0, c + 2);

        repeat (4) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/burst_ram_model.md
Name: burst_ram_model

Overview:
- Parametrised, byte-addressed behavioural memory that stands in for external DDR when verifying the AXI DDR controller logic.
- Separate read and write channels, so there is no tri-state bus. Writes and reads run concurrently.
- Supports length-counted bursts, per-byte write strobes, configurable read latency, and flags out-of-range accesses.
- Sits below the controller's native user interface in simulation benches.

Parameters:
- DATA_WIDTH, 64, beat width in bits; multiple of 8, 16..512. BPB = DATA_WIDTH/8 bytes per beat.
- ADDR_WIDTH, 30, byte-address width.
- MEM_BYTES, 8192, storage size in bytes; multiple of BPB.
- RD_LATENCY, 1, cycles from read issue to data valid; 1..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- wr_req  in  1  start write burst; sampled only when wr_busy=0
- wr_addr  in  ADDR_WIDTH  write burst start byte address
- wr_len  in  8  write beats minus 1 (0..255)
- wr_valid  in  1  write beat present
- wr_data  in  DATA_WIDTH  write beat data
- wr_strb  in  BPB  byte enables
- wr_busy  out  1  write burst in progress
- wr_done  out  1  one-cycle pulse after last write beat
- rd_req  in  1  start read burst; sampled only when rd_busy=0
- rd_addr  in  ADDR_WIDTH  read burst start byte address
- rd_len  in  8  read beats minus 1
- rd_busy  out  1  read burst in progress, including the latency pipeline
- rd_valid  out  1  read beat valid
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  marks final read beat
- err  out  1  sticky out-of-range flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, both FSMs IDLE, read pipeline flushed.
- Storage is not cleared by reset. It initialises to all zeros at time zero. A reset mid-burst aborts both bursts immediately, and a partly written burst stays written.
- Byte lane mapping: lane i is bits [DATA_WIDTH-1-8i : DATA_WIDTH-8-8i]. Lane i maps to byte address beat_addr+i, so lane 0 is the MSB (big-endian lanes). wr_strb[i] enables lane i.
- Address handling: the start address is aligned down to a multiple of BPB. Each beat advances the address by BPB. There is no wrap within a burst.
- Out-of-range beats: a beat whose aligned address is >= MEM_BYTES is out of range. Its writes are dropped, its reads return 0, and it sets err. err stays 1 until reset.
- Write FSM states: IDLE, WBURST.
  - IDLE -> WBURST when wr_req=1 at a clock edge. That edge latches addr and len, and wr_busy goes 1.
  - In WBURST, each edge with wr_valid=1 writes the strobed bytes, increments the address and decrements the beat count.
  - On the edge accepting the last beat, the FSM returns to IDLE, wr_busy goes 0 and wr_done pulses for one cycle.
  - wr_valid in IDLE is ignored. Beats with wr_strb=0 still count.
- Read FSM states: IDLE, RISSUE, RDRAIN.
  - IDLE -> RISSUE when rd_req=1 at an edge. That edge latches addr and len, and rd_busy goes 1.
  - RISSUE issues one beat per cycle, starting on the cycle after the req edge, with no back-pressure. Each issued beat samples memory and enters an RD_LATENCY-deep pipeline carrying data, valid and last.
  - Beat k is visible on rd_valid/rd_data during cycle (req edge)+RD_LATENCY+k. Beats are contiguous.
  - After the last issue the FSM goes to RDRAIN. RDRAIN -> IDLE when the last beat leaves the pipeline. rd_busy drops on the edge after the rd_last cycle.
  - rd_data is 0 whenever rd_valid=0.
- Same-edge read and write to the same byte: the read returns the pre-write value.
- Requests arriving while the corresponding busy=1 are ignored, with no queueing.

Test Plan:
- Reset, then write burst addr=0x10, len=3, data 0x0001..0004, strb all 1s; then read the same burst with RD_LATENCY=1 -> wr_done pulses once after beat 4. rd_valid is high for 4 cycles starting 1 cycle after the rd_req edge, data 0x0001..0004, rd_last on the 4th beat.
- Write 0x1122334455667788 to 0x40 with strb=0xFF. Then write 0xAAAAAAAAAAAAAAAA with strb=0x0F (lanes 0-3). Then read -> 0xAAAAAAAA55667788; byte at 0x40 reads 0xAA.
- Unaligned rd_addr=0x45 after the previous test -> data from 0x40 returned; err stays 0.
- Write len=1 at MEM_BYTES-8 -> first beat stored, second dropped, err=1 and held until rst_n pulse.
- RD_LATENCY=4, read len=7 with a concurrent write burst elsewhere -> first rd_valid 4 cycles after the req edge, 8 contiguous beats, write unaffected.
- Assert rst_n=0 mid read burst -> rd_valid, rd_busy and rd_last go 0 asynchronously, FSMs IDLE; a subsequent read returns previously written data intact.
